// File: rtl/gan_layer_sequencer_pkg.sv
// Shared state encoding, parameter defaults and a saturating counter helper
// for the GAN generator layer sequencer.
package gan_layer_sequencer_pkg;

   localparam int NUM_LAYERS_DEF = 3;
   localparam int TIMEOUT_DEF    = 20000;
   localparam int WD_W_DEF       = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_WAIT   = 3'd2,
      S_LATCH  = 3'd3,
      S_OUTPUT = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/gan_layer_sequencer_watchdog.sv
// Per-layer watchdog: cleared when a layer starts, counts while waiting on it.
// expired is combinational on the registered count, so the FSM reacts on the same edge.
module gan_layer_sequencer_watchdog #(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int WD_W           = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            enable,
   output logic [WD_W-1:0] count,
   output logic            expired
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == WD_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/gan_layer_sequencer.sv
// Control-only sequencer: accepts a latent vector, starts each MAC layer in turn,
// strobes the inter-layer buffers and holds the result with valid/ready; one run at a time.
module gan_layer_sequencer
   import gan_layer_sequencer_pkg::*;
#(
   parameter int NUM_LAYERS     = NUM_LAYERS_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int WD_W           = WD_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  in_latch,
   output logic [NUM_LAYERS-1:0] layer_start,
   input  logic [NUM_LAYERS-1:0] layer_done,
   output logic [NUM_LAYERS-1:0] stage_latch,
   output logic [2:0]            cur_layer,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  error,
   input  logic                  clear_err,
   output logic [31:0]           run_cycles
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_LAYERS - 1);

   state_t                state, state_nxt;
   logic [2:0]            idx, idx_nxt;
   logic                  ready_en;
   logic [31:0]           run_cnt;
   logic [NUM_LAYERS-1:0] idx_sel;
   logic                  done_sel;
   logic                  accept;
   logic [WD_W-1:0]       wd_count;
   logic                  wd_expired;
   logic                  first_wait;

   gan_layer_sequencer_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .WD_W           (WD_W)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == S_START),
      .enable  (state == S_WAIT),
      .count   (wd_count),
      .expired (wd_expired)
   );

   // Only the done of the layer being sequenced matters; the count is zero in
   // the first WAIT cycle, which masks a done left over from the previous run.
   assign idx_sel    = NUM_LAYERS'(1) << idx;
   assign done_sel   = |(layer_done & idx_sel);
   assign first_wait = (wd_count == '0);
   assign accept     = in_ready && in_valid;

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      in_ready    = 1'b0;
      layer_start = '0;
      stage_latch = '0;
      out_valid   = 1'b0;
      error       = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = ready_en && !rst;
            if (in_valid && ready_en) begin
               state_nxt = S_START;
               idx_nxt   = 3'd0;
            end
         end
         S_START: begin
            layer_start = rst ? '0 : idx_sel;
            state_nxt   = S_WAIT;
         end
         S_WAIT: begin
            if (done_sel && !first_wait) begin
               state_nxt = S_LATCH;
            end else if (wd_expired) begin
               state_nxt = S_ERROR;
            end
         end
         S_LATCH: begin
            stage_latch = rst ? '0 : idx_sel;
            if (idx == LAST_IDX) begin
               state_nxt = S_OUTPUT;
            end else begin
               idx_nxt   = idx + 3'd1;
               state_nxt = S_START;
            end
         end
         S_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         S_ERROR: begin
            error = 1'b1;
            if (clear_err) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign in_latch  = accept;
   assign busy      = (state != S_IDLE);
   assign cur_layer = idx;

   // ready_en holds off acceptance for one cycle after reset releases.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= 3'd0;
         ready_en   <= 1'b0;
         run_cnt    <= 32'd0;
         run_cycles <= 32'd0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         ready_en <= 1'b1;
         if (accept) begin
            run_cnt <= 32'd0;
         end else if (state != S_IDLE) begin
            run_cnt <= sat_inc32(run_cnt);
         end
         if (state == S_LATCH && state_nxt == S_OUTPUT) begin
            run_cycles <= sat_inc32(run_cnt);
         end
      end
   end

endmodule

// File: tb/tb_gan_layer_sequencer.sv
// Directed bench for gan_layer_sequencer with stub layers that raise done
// K cycles after their start pulse; expected run lengths flow through a queue.
module tb_gan_layer_sequencer;

   localparam int NL = 3;
   localparam int K  = 5;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_latch;
   logic [NL-1:0] layer_start;
   logic [NL-1:0] layer_done;
   logic [NL-1:0] stage_latch;
   logic [2:0]    cur_layer;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          error;
   logic          clear_err = 1'b0;
   logic [31:0]   run_cycles;

   logic [NL-1:0] never_done = '0;
   logic [NL-1:0] force_done = '0;
   logic [7:0]    stub_cnt [NL];
   logic [NL-1:0] stub_done;

   int cyc = 0;
   int latch_cyc = 0;
   int n_latch = 0;
   int n_start = 0;
   int bad_onehot = 0;
   int st_cyc [NL];
   int sl_cyc [NL];
   int n_cmp = 0;
   int n_err = 0;
   int exp_q [$];

   gan_layer_sequencer #(
      .NUM_LAYERS     (NL),
      .TIMEOUT_CYCLES (TO),
      .WD_W           (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_latch    (in_latch),
      .layer_start (layer_start),
      .layer_done  (layer_done),
      .stage_latch (stage_latch),
      .cur_layer   (cur_layer),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .error       (error),
      .clear_err   (clear_err),
      .run_cycles  (run_cycles)
   );

   always #5 clk = ~clk;

   // Stub layers: done rises K cycles after the start pulse, drops on the next start.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NL; i++) begin
         if (rst) begin
            stub_cnt[i] <= 8'd0;
         end else if (layer_start[i]) begin
            stub_cnt[i] <= 8'd1;
         end else if (stub_cnt[i] != 8'd0 && stub_cnt[i] < 8'(K)) begin
            stub_cnt[i] <= stub_cnt[i] + 8'd1;
         end
      end
   end

   always_comb begin
      stub_done = '0;
      for (int i = 0; i < NL; i++) begin
         stub_done[i] = (stub_cnt[i] == 8'(K));
      end
   end

   assign layer_done = (stub_done & ~never_done) | force_done;

   // Event recorder, sampled mid-cycle.
   always @(negedge clk) begin
      if (in_latch) begin
         latch_cyc = cyc;
         n_latch++;
      end
      for (int i = 0; i < NL; i++) begin
         if (layer_start[i]) begin
            st_cyc[i] = cyc;
            n_start++;
         end
         if (stage_latch[i]) sl_cyc[i] = cyc;
      end
      if ($countones(layer_start) > 1 || $countones(stage_latch) > 1) bad_onehot++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_run(input string tag);
      in_valid = 1'b1;
      #1;
      chk({tag, " in_latch"}, 32'(in_latch), 1);
      tick();
      in_valid = 1'b0;
   endtask

   // Waits for the result, then checks it against the next scoreboard entry.
   task automatic end_run(input string tag, input int exp_lat);
      int k;
      int exp_rc;
      k = 0;
      while (out_valid !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      chk({tag, " out_valid"}, 32'(out_valid), 1);
      exp_rc = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk({tag, " run_cycles"}, run_cycles, exp_rc);
      chk({tag, " latency"}, cyc - latch_cyc, exp_lat);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int ns;
      int nl;
      #1000000;
      $display("FAIL global_timeout: observed cycle %0d required completion", cyc);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int ns;
      int nl;

      // Reset state
      repeat (3) tick();
      chk("rst in_ready", 32'(in_ready), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst error", 32'(error), 0);
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst run_cycles", run_cycles, 0);
      chk("rst cur_layer", 32'(cur_layer), 0);
      chk("rst starts", 32'(layer_start), 0);
      rst = 1'b0;
      #1;
      chk("deassert in_ready", 32'(in_ready), 0);
      tick();
      chk("post_rst in_ready", 32'(in_ready), 1);

      // 1: single run, K=5 for every layer
      ns = n_start;
      exp_q.push_back(21);
      start_run("t1");
      end_run("t1", 22);
      chk("t1 start0", st_cyc[0] - latch_cyc, 1);
      chk("t1 start1 gap", st_cyc[1] - st_cyc[0], 7);
      chk("t1 start2 gap", st_cyc[2] - st_cyc[1], 7);
      chk("t1 latch0", sl_cyc[0] - st_cyc[0], 6);
      chk("t1 latch2", sl_cyc[2] - latch_cyc, 21);
      chk("t1 nstart", n_start - ns, 3);
      chk("t1 busy", 32'(busy), 1);

      // 2: downstream stall holds the result
      ns = n_start;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2 hold out_valid", 32'(out_valid), 1);
         chk("t2 hold in_ready", 32'(in_ready), 0);
      end
      chk("t2 no start", n_start - ns, 0);
      chk("t2 run_cycles held", run_cycles, 21);
      handshake();
      chk("t2 release out_valid", 32'(out_valid), 0);
      chk("t2 release in_ready", 32'(in_ready), 1);

      // 3: layer 1 never finishes -> watchdog
      never_done[1] = 1'b1;
      start_run("t3");
      for (int k = 0; k < 400 && error !== 1'b1; k++) tick();
      chk("t3 error", 32'(error), 1);
      chk("t3 wait cycles", cyc - st_cyc[1], TO + 1);
      chk("t3 cur_layer", 32'(cur_layer), 1);
      chk("t3 in_ready", 32'(in_ready), 0);
      chk("t3 busy", 32'(busy), 1);
      ns = n_start;
      repeat (20) tick();
      chk("t3 no start", n_start - ns, 0);
      chk("t3 sticky", 32'(error), 1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("t3 cleared", 32'(error), 0);
      chk("t3 idle busy", 32'(busy), 0);
      chk("t3 idle in_ready", 32'(in_ready), 1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("t3 stray clear busy", 32'(busy), 0);
      chk("t3 stray clear in_ready", 32'(in_ready), 1);
      never_done[1] = 1'b0;

      // 4a: stale done on layer 0 is ignored in the first WAIT cycle
      force_done[0] = 1'b1;
      exp_q.push_back(18);
      start_run("t4a");
      end_run("t4a", 19);
      chk("t4a latch0", sl_cyc[0] - latch_cyc, 4);
      force_done[0] = 1'b0;
      handshake();

      // 4b: spurious done on layer 2 during layer 0 WAIT
      exp_q.push_back(21);
      start_run("t4b");
      force_done[2] = 1'b1;
      repeat (4) tick();
      force_done[2] = 1'b0;
      end_run("t4b", 22);
      chk("t4b latch0", sl_cyc[0] - latch_cyc, 7);
      handshake();

      // 5: reset in WAIT of layer 1
      start_run("t5");
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b1;
      #1;
      chk("t5 in_ready", 32'(in_ready), 0);
      chk("t5 in_latch", 32'(in_latch), 0);
      chk("t5 busy", 32'(busy), 0);
      chk("t5 starts", 32'(layer_start), 0);
      chk("t5 latches", 32'(stage_latch), 0);
      chk("t5 cur_layer", 32'(cur_layer), 0);
      chk("t5 run_cycles", run_cycles, 0);
      tick();
      exp_q.push_back(21);
      chk("t5 relaunch latch", 32'(in_latch), 1);
      tick();
      in_valid = 1'b0;
      end_run("t5", 22);
      handshake();

      // 6: in_valid held high across two runs
      nl = n_latch;
      exp_q.push_back(21);
      exp_q.push_back(21);
      in_valid = 1'b1;
      tick();
      end_run("t6 first", 22);
      repeat (3) tick();
      chk("t6 single latch", n_latch - nl, 1);
      handshake();
      chk("t6 second latch", 32'(in_latch), 1);
      chk("t6 latch count", n_latch - nl, 1);
      tick();
      in_valid = 1'b0;
      end_run("t6 second", 22);
      handshake();
      chk("t6 onehot", bad_onehot, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
